rom_lookup_ctrl: RTL

Request/response front end for the synchronous lookup ROM (2-cycle read latency, address on `addra`/`ena`, data on `douta`). Accepts tagged address requests over a valid/ready handshake, issues them to the ROM, realigns returned data with its tag using a latency-matched valid pipe, and buffers results in a small FIFO so the consumer can apply backpressure without losing data. Sits directly upstream of the ROM instance and downstream of the segment/lookup requesters.

---
 rtl/rom_lookup_pkg.sv | 17 +
 rtl/rom_rsp_fifo.sv | 59 +++++
 rtl/rom_lookup_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/rom_lookup_pkg.sv
// Shared definitions for the lookup ROM and its requesters.
package rom_lookup_pkg;

  // Read latency of the lookup ROM instance, in clocks.
  localparam int ROM_LAT_DEFAULT = 2;

  // Default field widths of a ROM response.
  localparam int RSP_DATB = 11;
  localparam int RSP_TAGB = 8;

  // One ROM response as seen by a requester.
  typedef struct packed {
    logic [RSP_DATB-1:0] data;
    logic [RSP_TAGB-1:0] tag;
  } rom_rsp_t;

endpackage

// File: rtl/rom_rsp_fifo.sv
// Generic synchronous first-word-fall-through FIFO built from registers,
// with an occupancy counter kept separately from the pointers.
module rom_rsp_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clka,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             rd_fire;

  // A pop on an empty FIFO is ignored.
  assign rd_fire = rd_en && (count != '0);

  // Head entry falls through straight from storage.
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset on purpose so the head reads zero after reset;
      // a large RAM-style FIFO would normally leave its array unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here let every register sample the
      // pre-edge values, so pointer and count updates never see each other.
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTRW'(1);
      end
      if (rd_fire) rd_ptr <= rd_ptr + PTRW'(1);
      case ({wr_en, rd_fire})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Upstream flow control must never write into a full FIFO.
  a_no_overflow : assert property (@(posedge clka) disable iff (rst)
    !(wr_en && (count == CNTW'(DEPTH))));

endmodule

// File: rtl/rom_lookup_ctrl.sv
// Request/response front end for the 2-cycle synchronous lookup ROM:
// credit-based request acceptance, latency-matched valid/tag pipe and
// a small response FIFO so the consumer can backpressure.
module rom_lookup_ctrl
  import rom_lookup_pkg::*;
#(
  parameter int MXADRB     = 9,
  parameter int MXDATB     = 11,
  parameter int TAGB       = 8,
  parameter int ROM_LAT    = ROM_LAT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clka,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [MXADRB-1:0]             req_addr,
  input  logic [TAGB-1:0]               req_tag,
  output logic                          rom_ena,
  output logic [MXADRB-1:0]             rom_addra,
  input  logic [MXDATB-1:0]             rom_douta,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MXDATB-1:0]             rsp_data,
  output logic [TAGB-1:0]               rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic                accept;
  logic [ROM_LAT-1:0]  vld_pipe;
  logic [TAGB-1:0]     tag_pipe [ROM_LAT];
  logic [CNTW:0]       inflight;
  logic [CNTW:0]       credit_used;

  // Count lookups issued to the ROM whose data has not yet reached the FIFO.
  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely
    // combinational; a path that skips the assignment would infer a latch.
    inflight = '0;
    for (int k = 0; k < ROM_LAT; k++) inflight += {{CNTW{1'b0}}, vld_pipe[k]};
  end

  // Credits come from registered state only, so a pop frees a slot one
  // cycle later and there is no path from req_valid or rsp_ready.
  assign credit_used = {1'b0, fifo_count} + inflight;
  assign req_ready   = !rst && (credit_used < (CNTW + 1)'(FIFO_DEPTH));

  assign accept    = req_valid && req_ready;
  assign rom_ena   = accept;
  assign rom_addra = req_addr;

  // Valid/tag pipe tracking the ROM read latency; reset masks stale ROM data.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < ROM_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= req_tag;
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // Response buffer; the last pipe stage writes ROM data paired with its tag.
  rom_rsp_fifo #(
    .WIDTH (MXDATB + TAGB),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clka    (clka),
    .rst     (rst),
    .wr_en   (vld_pipe[ROM_LAT-1]),
    .wr_data ({rom_douta, tag_pipe[ROM_LAT-1]}),
    .rd_en   (rsp_ready),
    .rd_data ({rsp_data, rsp_tag}),
    .count   (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);

endmodule
